// File: rtl/quad_stepper_pkg.sv
// Shared types and default timing for the quadrature-to-stepper path.
// Timing defaults are in clk cycles.
package quad_stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIR_SETUP,
        ST_PULSE_HIGH,
        ST_PULSE_LOW
    } step_state_t;

    localparam int DEF_DIR_SETUP_CYCLES  = 10;
    localparam int DEF_PULSE_HIGH_CYCLES = 20;
    localparam int DEF_PULSE_LOW_CYCLES  = 20;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; holds at zero until reloaded.
// zero is decoded from the registered count.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (!zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/step_pulse_generator.sv
// Turns detector step pulses into STEP/DIR with driver setup/high/low timing.
// Pending steps are held in a signed saturating counter.
module step_pulse_generator
    import quad_stepper_pkg::*;
#(
    parameter int PEND_W            = 8,
    parameter int TIMER_W           = 16,
    parameter int DIR_SETUP_CYCLES  = DEF_DIR_SETUP_CYCLES,
    parameter int PULSE_HIGH_CYCLES = DEF_PULSE_HIGH_CYCLES,
    parameter int PULSE_LOW_CYCLES  = DEF_PULSE_LOW_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic step_in,
    input  logic dir_up_in,
    output logic step_out,
    output logic dir_out,
    output logic busy,
    output logic overflow
);

    if (DIR_SETUP_CYCLES < 1 || DIR_SETUP_CYCLES >= 2**TIMER_W ||
        PULSE_HIGH_CYCLES < 1 || PULSE_HIGH_CYCLES >= 2**TIMER_W ||
        PULSE_LOW_CYCLES < 1 || PULSE_LOW_CYCLES >= 2**TIMER_W) begin : g_bad_timing
        $error("step_pulse_generator: cycle parameter out of range");
    end

    localparam logic [TIMER_W-1:0] SETUP_LD = TIMER_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HIGH_LD  = TIMER_W'(PULSE_HIGH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOW_LD   = TIMER_W'(PULSE_LOW_CYCLES - 1);

    localparam logic signed [PEND_W:0] P_MAX = {2'b00, {(PEND_W-1){1'b1}}};
    localparam logic signed [PEND_W:0] P_MIN = {2'b11, {(PEND_W-1){1'b0}}};
    localparam logic signed [PEND_W:0] ONE   = {{PEND_W{1'b0}}, 1'b1};
    localparam logic signed [PEND_W:0] NEG1  = '1;

    step_state_t state;

    logic signed [PEND_W-1:0] pending;
    logic signed [PEND_W-1:0] pend_next;
    logic signed [PEND_W:0]   pend_x;
    logic signed [PEND_W:0]   d_in;
    logic signed [PEND_W:0]   d_iss;
    logic signed [PEND_W:0]   sum;

    logic pend_nz;
    logic pend_pos;
    logic pend_neg;
    logic match;
    logic issue;
    logic clamp_hi;
    logic clamp_lo;

    logic               t_load;
    logic [TIMER_W-1:0] t_value;
    logic               t_zero;

    cycle_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (t_load),
        .value(t_value),
        .zero (t_zero)
    );

    assign pend_nz  = (pending != '0);
    assign pend_neg = pending[PEND_W-1];
    assign pend_pos = pend_nz && !pend_neg;
    assign match    = dir_out ? pend_pos : pend_neg;

    // Issue decision and timer reload track the state transitions below
    always_comb begin
        issue   = 1'b0;
        t_load  = 1'b0;
        t_value = '0;
        unique case (state)
            ST_IDLE: begin
                if (pend_nz) begin
                    t_load = 1'b1;
                    if (match) begin
                        issue   = 1'b1;
                        t_value = HIGH_LD;
                    end else begin
                        t_value = SETUP_LD;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (t_zero && match) begin
                    issue   = 1'b1;
                    t_load  = 1'b1;
                    t_value = HIGH_LD;
                end
            end
            ST_PULSE_HIGH: begin
                if (t_zero) begin
                    t_load  = 1'b1;
                    t_value = LOW_LD;
                end
            end
            ST_PULSE_LOW: begin
            end
        endcase
    end

    // Net change is summed one bit wider so saturation can be detected
    always_comb begin
        pend_x = {pending[PEND_W-1], pending};
        d_in   = step_in ? (dir_up_in ? ONE : NEG1) : '0;
        d_iss  = issue ? (pend_pos ? NEG1 : ONE) : '0;
        sum    = pend_x + d_in + d_iss;
        clamp_hi = (sum > P_MAX);
        clamp_lo = (sum < P_MIN);
        unique case (1'b1)
            clamp_hi: pend_next = P_MAX[PEND_W-1:0];
            clamp_lo: pend_next = P_MIN[PEND_W-1:0];
            default:  pend_next = sum[PEND_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            step_out <= 1'b0;
            dir_out  <= 1'b1;
            overflow <= 1'b0;
            pending  <= '0;
        end else begin
            pending <= pend_next;
            if (clamp_hi || clamp_lo) begin
                overflow <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (pend_nz) begin
                        if (match) begin
                            state    <= ST_PULSE_HIGH;
                            step_out <= 1'b1;
                        end else begin
                            state   <= ST_DIR_SETUP;
                            dir_out <= ~dir_out;
                        end
                    end
                end
                ST_DIR_SETUP: begin
                    if (t_zero) begin
                        if (match) begin
                            state    <= ST_PULSE_HIGH;
                            step_out <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_PULSE_HIGH: begin
                    if (t_zero) begin
                        state    <= ST_PULSE_LOW;
                        step_out <= 1'b0;
                    end
                end
                ST_PULSE_LOW: begin
                    if (t_zero) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE) || pend_nz;

endmodule

// File: tb/tb_step_pulse_generator.sv
// Bench for step_pulse_generator: timeline reference model plus directed
// literal checks and a randomized run.
module tb_step_pulse_generator;

    localparam int S    = 10;
    localparam int H    = 20;
    localparam int L    = 20;
    localparam int PMAX = 127;
    localparam int PMIN = -128;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic step_in = 1'b0;
    logic dir_up_in = 1'b1;
    logic step_out;
    logic dir_out;
    logic busy;
    logic overflow;

    step_pulse_generator dut (
        .clk      (clk),
        .reset    (reset),
        .step_in  (step_in),
        .dir_up_in(dir_up_in),
        .step_out (step_out),
        .dir_out  (dir_out),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    bit chk_en = 0;

    // Reference: pending count, DIR level, and the timeline of decisions
    int m_pend;
    bit m_dir;
    bit m_ovf;
    int m_next;
    bit m_setup;
    int m_pstart;
    int m_pulses = 0;

    int rises = 0;
    int rise_q[$];
    bit prev_step = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d",
                     name, cyc_n, act, exp);
        end
    endtask

    task automatic m_reset();
        m_pend   = 0;
        m_dir    = 1;
        m_ovf    = 0;
        m_setup  = 0;
        m_next   = cyc_n + 1;
        m_pstart = -1000;
    endtask

    task automatic m_issue(input int e, output int iss);
        iss      = (m_pend > 0) ? -1 : 1;
        m_pstart = e;
        m_next   = e + H + L + 1;
        m_pulses++;
    endtask

    task automatic m_edge(input bit s, input bit d, input bit r);
        int e;
        int iss;
        int v;
        bit match;
        e   = cyc_n;
        iss = 0;
        if (r) begin
            m_reset();
            return;
        end
        match = (m_pend > 0 && m_dir) || (m_pend < 0 && !m_dir);
        if (e == m_next) begin
            if (m_setup) begin
                m_setup = 0;
                if (match) m_issue(e, iss);
                else m_next = e + 1;
            end else if (m_pend == 0) begin
                m_next = e + 1;
            end else if (match) begin
                m_issue(e, iss);
            end else begin
                m_dir   = !m_dir;
                m_setup = 1;
                m_next  = e + S;
            end
        end
        v = m_pend + (s ? (d ? 1 : -1) : 0) + iss;
        if (v > PMAX) begin
            v = PMAX;
            m_ovf = 1;
        end else if (v < PMIN) begin
            v = PMIN;
            m_ovf = 1;
        end
        m_pend = v;
    endtask

    task automatic tick(input bit s, input bit d, input bit r);
        step_in   = s;
        dir_up_in = d;
        reset     = r;
        @(posedge clk);
        cyc_n++;
        m_edge(s, d, r);
        #1;
        step_in = 0;
        reset   = 0;
    endtask

    task automatic run_until(input int c);
        while (cyc_n < c) tick(0, 1, 0);
    endtask

    task automatic do_reset();
        tick(0, 1, 1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int c;
            bool_chk: begin
                c = cyc_n;
                chk("step_out", step_out,
                    (c >= m_pstart && c < m_pstart + H) ? 1 : 0);
                chk("dir_out", dir_out, m_dir ? 1 : 0);
                chk("overflow", overflow, m_ovf ? 1 : 0);
                chk("busy", busy,
                    (m_setup || c != m_next - 1 || m_pend != 0) ? 1 : 0);
                chk("pending", $signed(dut.pending), m_pend);
            end
            if (step_out === 1'b1 && !prev_step) begin
                rises++;
                rise_q.push_back(c);
            end
            prev_step = (step_out === 1'b1);
        end
    end

    initial begin
        int b;
        int n0;
        int qs;
        int dens;
        int bias;

        do_reset();
        chk_en = 1;
        chk("rst_step", step_out, 0);
        chk("rst_dir", dir_out, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);

        // Single up step
        b = cyc_n;
        tick(1, 1, 0);
        chk("t1_c1_step", step_out, 0);
        run_until(b + 2);
        chk("t1_c2_step", step_out, 1);
        run_until(b + 21);
        chk("t1_c21_step", step_out, 1);
        run_until(b + 22);
        chk("t1_c22_step", step_out, 0);
        run_until(b + 41);
        chk("t1_c41_busy", busy, 1);
        run_until(b + 42);
        chk("t1_c42_busy", busy, 0);
        chk("t1_dir", dir_out, 1);
        chk("t1_pend", $signed(dut.pending), 0);

        // Single down step
        do_reset();
        n0 = rises;
        b  = cyc_n;
        tick(1, 0, 0);
        chk("t2_c1_dir", dir_out, 1);
        run_until(b + 2);
        chk("t2_c2_dir", dir_out, 0);
        run_until(b + 11);
        chk("t2_c11_step", step_out, 0);
        chk("t2_no_early", rises - n0, 0);
        run_until(b + 12);
        chk("t2_c12_step", step_out, 1);
        run_until(b + 31);
        chk("t2_c31_step", step_out, 1);
        run_until(b + 32);
        chk("t2_c32_step", step_out, 0);

        // Five consecutive up steps
        do_reset();
        n0 = rises;
        qs = rise_q.size();
        b  = cyc_n;
        repeat (5) tick(1, 1, 0);
        run_until(b + 5 * 41 + 10);
        chk("t3_count", rises - n0, 5);
        chk("t3_first", rise_q[qs] - b, 2);
        for (int k = 1; k < 5; k++) begin
            chk("t3_period", rise_q[qs + k] - rise_q[qs + k - 1], 41);
        end
        chk("t3_ovf", overflow, 0);

        // 300-step burst saturates
        do_reset();
        n0 = rises;
        b  = cyc_n;
        repeat (300) tick(1, 1, 0);
        chk("t4_pend_sat", $signed(dut.pending), 127);
        chk("t4_ovf", overflow, 1);
        chk("t4_burst_issued", rises - n0, 8);
        run_until(b + 300 + 127 * 41 + 100);
        chk("t4_total", rises - n0, 135);
        chk("t4_pend_end", $signed(dut.pending), 0);
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_busy", busy, 0);
        do_reset();
        chk("t4_ovf_clr", overflow, 0);

        // Up then down on consecutive cycles
        b = cyc_n;
        tick(1, 1, 0);
        tick(1, 0, 0);
        run_until(b + 2);
        chk("t5_c2_step", step_out, 1);
        run_until(b + 21);
        chk("t5_c21_step", step_out, 1);
        run_until(b + 22);
        chk("t5_c22_step", step_out, 0);
        run_until(b + 42);
        chk("t5_c42_dir", dir_out, 1);
        run_until(b + 43);
        chk("t5_c43_dir", dir_out, 0);
        run_until(b + 52);
        chk("t5_c52_step", step_out, 0);
        run_until(b + 53);
        chk("t5_c53_step", step_out, 1);
        run_until(b + 72);
        chk("t5_c72_step", step_out, 1);
        run_until(b + 73);
        chk("t5_c73_step", step_out, 0);
        run_until(b + 120);
        chk("t5_pend", $signed(dut.pending), 0);

        // Reset in the middle of a high pulse
        do_reset();
        b = cyc_n;
        tick(1, 1, 0);
        tick(1, 1, 0);
        run_until(b + 11);
        chk("t6_mid_step", step_out, 1);
        tick(0, 1, 1);
        chk("t6_step", step_out, 0);
        chk("t6_dir", dir_out, 1);
        chk("t6_pend", $signed(dut.pending), 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_busy", busy, 0);
        n0 = rises;
        run_until(cyc_n + 100);
        chk("t6_no_pulse", rises - n0, 0);

        // Randomized traffic with changing density and direction bias
        dens = 10;
        bias = 50;
        for (int i = 0; i < 8000; i++) begin
            if (i % 250 == 0) begin
                dens = $urandom_range(95, 1);
                bias = $urandom_range(100, 0);
            end
            tick($urandom_range(99, 0) < dens,
                 $urandom_range(99, 0) < bias,
                 $urandom_range(2999, 0) == 0);
        end
        repeat (300) tick(0, 1, 0);
        do_reset();
        run_until(cyc_n + 5);
        chk("rand_pulses", rises, m_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
